// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU stage.
// Contents: operation-select encodings, flag bit positions inside the
// {Z,C,N,O} flag register, and the control FSM state type.
package alu_pkg;

    // Operation select encodings.
    localparam logic [4:0] FS_A    = 5'b00000;
    localparam logic [4:0] FS_B    = 5'b00001;
    localparam logic [4:0] FS_NOTA = 5'b00010;
    localparam logic [4:0] FS_NOTB = 5'b00011;
    localparam logic [4:0] FS_ADD  = 5'b00100;
    localparam logic [4:0] FS_ADC  = 5'b00101;
    localparam logic [4:0] FS_SUB  = 5'b00110;
    localparam logic [4:0] FS_AND  = 5'b00111;
    localparam logic [4:0] FS_OR   = 5'b01000;
    localparam logic [4:0] FS_XOR  = 5'b01001;
    localparam logic [4:0] FS_NAND = 5'b01010;
    localparam logic [4:0] FS_LSL  = 5'b01011;
    localparam logic [4:0] FS_LSR  = 5'b01100;
    localparam logic [4:0] FS_ASR  = 5'b01101;
    localparam logic [4:0] FS_CSL  = 5'b01110;
    localparam logic [4:0] FS_CSR  = 5'b01111;
    localparam logic [4:0] FS_MUL  = 5'b10000;

    // Flag register bit positions.
    localparam int unsigned FLG_Z = 3;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_O = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StFin  = 2'd2
    } alu_state_e;

    // Encodings above FS_MUL leave result and flags untouched.
    function automatic logic is_reserved(input logic [4:0] fs);
        return fs > FS_MUL;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture a/b and clear the accumulator
//   step       : perform one shift-add iteration
//   a, b       : operands (only sampled on load)
//   product    : full 2*WIDTH accumulator; valid after WIDTH steps
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
        end else if (step) begin
            // Add the shifted multiplicand when the current multiplier LSB is set.
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign product = prod_q;

endmodule

// File: rtl/alu_seq_unit.sv
// 16-bit ALU stage with registered result and {Z,C,N,O} flags.
// Single-cycle ops commit on the Start edge; MUL runs MUL_CYCLES shift-add
// steps in alu_mul_seq and commits from the FIN state.
// Ports:
//   Clock, Reset : rising-edge clock, asynchronous active-low reset
//   A, B         : operands from the register file
//   FunSel, WF   : operation select and flag-write enable, sampled on Start
//   Start        : begin an operation; ignored while Busy
//   ALUOut       : registered result
//   FlagsOut     : {Z,C,N,O}
//   Busy         : multiply in flight
//   Done         : one-cycle pulse after result/flags commit
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MUL_CYCLES = 16  // must equal WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FunSel,
    input  logic             WF,
    input  logic             Start,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

    alu_state_e         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q, done_d;
    logic               wf_q, wf_d;

    logic               mul_load, mul_step;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   op_res;
    logic               op_c, op_o, upd_c, upd_o;
    logic [3:0]         flags_op, flags_mul;
    logic               mul_hi_nz;

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (Clock),
        .rst_n  (Reset),
        .load   (mul_load),
        .step   (mul_step),
        .a      (A),
        .b      (B),
        .product(mul_product)
    );

    // Single-cycle datapath; upd_c/upd_o mark ops that define C/O.
    always_comb begin
        sum    = '0;
        op_res = '0;
        op_c   = 1'b0;
        op_o   = 1'b0;
        upd_c  = 1'b0;
        upd_o  = 1'b0;
        case (FunSel)
            FS_A:    op_res = A;
            FS_B:    op_res = B;
            FS_NOTA: op_res = ~A;
            FS_NOTB: op_res = ~B;
            FS_ADD, FS_ADC: begin
                sum    = {1'b0, A} + {1'b0, B}
                         + {{WIDTH{1'b0}}, (FunSel == FS_ADC) & flags_q[FLG_C]};
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_o   = (A[WIDTH-1] == B[WIDTH-1]) && (op_res[WIDTH-1] != A[WIDTH-1]);
                upd_c  = 1'b1;
                upd_o  = 1'b1;
            end
            FS_SUB: begin
                sum    = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_o   = (A[WIDTH-1] != B[WIDTH-1]) && (op_res[WIDTH-1] != A[WIDTH-1]);
                upd_c  = 1'b1;
                upd_o  = 1'b1;
            end
            FS_AND:  op_res = A & B;
            FS_OR:   op_res = A | B;
            FS_XOR:  op_res = A ^ B;
            FS_NAND: op_res = ~(A & B);
            FS_LSL: begin
                op_res = {A[WIDTH-2:0], 1'b0};
                op_c   = A[WIDTH-1];
                upd_c  = 1'b1;
            end
            FS_LSR: begin
                op_res = {1'b0, A[WIDTH-1:1]};
                op_c   = A[0];
                upd_c  = 1'b1;
            end
            FS_ASR: begin
                op_res = {A[WIDTH-1], A[WIDTH-1:1]};
                op_c   = A[0];
                upd_c  = 1'b1;
            end
            FS_CSL: begin
                op_res = {A[WIDTH-2:0], flags_q[FLG_C]};
                op_c   = A[WIDTH-1];
                upd_c  = 1'b1;
            end
            FS_CSR: begin
                op_res = {flags_q[FLG_C], A[WIDTH-1:1]};
                op_c   = A[0];
                upd_c  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        flags_op        = flags_q;
        flags_op[FLG_Z] = (op_res == '0);
        flags_op[FLG_N] = op_res[WIDTH-1];
        if (upd_c) flags_op[FLG_C] = op_c;
        if (upd_o) flags_op[FLG_O] = op_o;
    end

    // C and O both report truncation of the product.
    assign mul_hi_nz = |mul_product[2*WIDTH-1:WIDTH];

    always_comb begin
        flags_mul        = '0;
        flags_mul[FLG_Z] = (mul_product[WIDTH-1:0] == '0);
        flags_mul[FLG_C] = mul_hi_nz;
        flags_mul[FLG_N] = mul_product[WIDTH-1];
        flags_mul[FLG_O] = mul_hi_nz;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_out_d = alu_out_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        wf_d      = wf_q;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    if (FunSel == FS_MUL) begin
                        mul_load = 1'b1;
                        wf_d     = WF;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        done_d = 1'b1;
                        if (!is_reserved(FunSel)) begin
                            alu_out_d = op_res;
                            if (WF) flags_d = flags_op;
                        end
                    end
                end
            end
            StMul: begin
                mul_step = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntW'(MUL_CYCLES - 1)) state_d = StFin;
            end
            StFin: begin
                alu_out_d = mul_product[WIDTH-1:0];
                if (wf_q) flags_d = flags_mul;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            alu_out_q <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            wf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            wf_q      <= wf_d;
        end
    end

    assign ALUOut   = alu_out_q;
    assign FlagsOut = flags_q;
    assign Busy     = (state_q != StIdle);
    assign Done     = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed vector table, hand-written
// multiply/reset/back-to-back sequences, then random ops against a model.
module tb_alu_seq_unit;
    import alu_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [15:0] A, B;
    logic [4:0]  FunSel;
    logic        WF;
    logic        Start;
    logic [15:0] ALUOut;
    logic [3:0]  FlagsOut;
    logic        Busy;
    logic        Done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [15:0] m_out;
    logic [3:0]  m_flags;

    alu_seq_unit #(
        .WIDTH(16),
        .MUL_CYCLES(16)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .A       (A),
        .B       (B),
        .FunSel  (FunSel),
        .WF      (WF),
        .Start   (Start),
        .ALUOut  (ALUOut),
        .FlagsOut(FlagsOut),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the operation rules.
    task automatic ref_exec(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b,
                            input logic wf);
        int ua, ub, sa, sb, cin, s, ss;
        longint p;
        logic [15:0] r;
        logic c, o, wc, wo;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        cin = m_flags[2];
        r = '0; c = 0; o = 0; wc = 0; wo = 0;
        if (fs > 5'd16) return;
        case (fs)
            5'd0:  r = a;
            5'd1:  r = b;
            5'd2:  r = ~a;
            5'd3:  r = ~b;
            5'd4, 5'd5: begin
                if (fs == 5'd4) cin = 0;
                s = ua + ub + cin; ss = sa + sb + cin;
                r = s[15:0]; c = (s > 65535); o = (ss > 32767) || (ss < -32768);
                wc = 1; wo = 1;
            end
            5'd6: begin
                s = ua - ub; ss = sa - sb;
                r = s[15:0]; c = (ua >= ub); o = (ss > 32767) || (ss < -32768);
                wc = 1; wo = 1;
            end
            5'd7:  r = a & b;
            5'd8:  r = a | b;
            5'd9:  r = a ^ b;
            5'd10: r = ~(a & b);
            5'd11: begin r = 16'(ua * 2);           c = (ua >= 32768); wc = 1; end
            5'd12: begin r = 16'(ua / 2);           c = (ua % 2) != 0; wc = 1; end
            5'd13: begin r = 16'(sa >>> 1);         c = (ua % 2) != 0; wc = 1; end
            5'd14: begin r = 16'(ua * 2 + cin);     c = (ua >= 32768); wc = 1; end
            5'd15: begin r = 16'(ua / 2 + cin * 32768); c = (ua % 2) != 0; wc = 1; end
            default: begin
                p = longint'(ua) * longint'(ub);
                r = p[15:0]; c = (p >> 16) != 0; o = c; wc = 1; wo = 1;
            end
        endcase
        if (wf) m_flags = {r == 16'h0, wc ? c : m_flags[2], r[15], wo ? o : m_flags[0]};
        m_out = r;
    endtask

    // Issue one op and check it against the model. For MUL, operands are
    // scrambled and a stray Start is issued while Busy.
    task automatic run_op(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b,
                          input logic wf);
        int n, busy_n;
        FunSel = fs; A = a; B = b; WF = wf; Start = 1'b1;
        tick();
        Start = 1'b0;
        ref_exec(fs, a, b, wf);
        if (fs == FS_MUL) begin
            n = 0; busy_n = 0;
            while (Done !== 1'b1 && n < 40) begin
                if (Busy === 1'b1) busy_n++;
                if (n == 3) begin
                    Start = 1'b1;
                    FunSel = 5'($urandom_range(0, 16));
                    WF = 1'($urandom);
                end
                if (n == 4) Start = 1'b0;
                A = 16'($urandom); B = 16'($urandom);
                tick();
                n++;
            end
            check("mul_latency", n, 17);
            check("mul_busy_cycles", busy_n, 17);
            check("busy_after_mul", Busy, 0);
        end
        check("done_pulse", Done, 1);
        check("alu_out", ALUOut, m_out);
        check("flags", FlagsOut, m_flags);
    endtask

    typedef struct {
        logic [4:0]  fs;
        logic        wf;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{FS_A,    1'b1, 16'h1234, 16'h0000, 16'h1234, 4'b0000};
        vecs[1]  = '{FS_ADD,  1'b1, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011};
        vecs[2]  = '{FS_SUB,  1'b1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0010};
        vecs[3]  = '{FS_SUB,  1'b0, 16'h0005, 16'h0005, 16'h0000, 4'b0010};
        vecs[4]  = '{FS_ADD,  1'b1, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100};
        vecs[5]  = '{FS_CSL,  1'b1, 16'h8001, 16'h0000, 16'h0003, 4'b0100};
        vecs[6]  = '{FS_ADC,  1'b1, 16'h0001, 16'h0001, 16'h0003, 4'b0000};
        vecs[7]  = '{FS_CSR,  1'b1, 16'h0001, 16'h0000, 16'h0000, 4'b1100};
        vecs[8]  = '{5'b11111, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1100};
        vecs[9]  = '{FS_XOR,  1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0100};
        vecs[10] = '{FS_ASR,  1'b1, 16'h8002, 16'h0000, 16'hC001, 4'b0010};
        vecs[11] = '{FS_LSL,  1'b1, 16'h8000, 16'h0000, 16'h0000, 4'b1100};
        vecs[12] = '{FS_NAND, 1'b1, 16'hFFFF, 16'h00FF, 16'hFF00, 4'b0110};
        vecs[13] = '{FS_LSR,  1'b1, 16'h0003, 16'h0000, 16'h0001, 4'b0100};
        vecs[14] = '{FS_NOTB, 1'b1, 16'h0000, 16'h8000, 16'h7FFF, 4'b0100};
        vecs[15] = '{FS_SUB,  1'b1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0101};

        Reset = 1'b0; Start = 1'b0; A = '0; B = '0; FunSel = '0; WF = 1'b0;
        m_out = '0; m_flags = '0;
        #1;
        check("reset_alu_out", ALUOut, 0);
        check("reset_flags", FlagsOut, 0);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        tick();
        tick();
        Reset = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].wf);
            check("tbl_out", ALUOut, vecs[i].out);
            check("tbl_flags", FlagsOut, vecs[i].flags);
            tick();
            check("tbl_done_low", Done, 0);
        end

        // Multiply with truncation, then back-to-back Start in the Done cycle
        run_op(FS_MUL, 16'h0100, 16'h0100, 1'b1);
        check("mul_out", ALUOut, 16'h0000);
        check("mul_flags", FlagsOut, 4'b1101);
        run_op(FS_A, 16'h5555, 16'h0000, 1'b0);
        check("b2b_out", ALUOut, 16'h5555);
        check("b2b_flags", FlagsOut, 4'b1101);

        // Reset asserted between edges, mid-multiply
        FunSel = FS_MUL; A = 16'h0003; B = 16'h0007; WF = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        #2;
        Reset = 1'b0;
        #1;
        check("midmul_reset_out", ALUOut, 0);
        check("midmul_reset_flags", FlagsOut, 0);
        check("midmul_reset_busy", Busy, 0);
        check("midmul_reset_done", Done, 0);
        m_out = '0; m_flags = '0;
        tick();
        Reset = 1'b1;
        run_op(FS_A, 16'h1234, 16'h0000, 1'b1);
        check("post_reset_out", ALUOut, 16'h1234);
        tick();
        check("post_reset_no_stale_done", Done, 0);

        // Random ops against the model
        for (int i = 0; i < 120; i++) begin
            logic [4:0] fs;
            fs = ($urandom_range(0, 4) == 0) ? FS_MUL : 5'($urandom_range(0, 31));
            run_op(fs, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- 16-bit ALU stage directly downstream of the register file; consumes its OutA/OutB as operands A/B.
- Produces a registered result ALUOut (fed back to the register file I input via the datapath mux) and a 4-bit flag register {Z,C,N,O}.
- Single-cycle ops complete in 1 clock; unsigned multiply runs as a 16-cycle iterative shift-add sequence with Start/Busy/Done handshake.

Parameters:
- WIDTH, 16, operand/result width; flag logic indexes bit WIDTH-1.
- MUL_CYCLES, 16, iterations of multiply; must equal WIDTH.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- A  input  WIDTH  operand A (from register file OutA)
- B  input  WIDTH  operand B (from register file OutB)
- FunSel  input  5  operation select, sampled on Start
- WF  input  1  write-flags enable, sampled on Start
- Start  input  1  begin operation; ignored while Busy
- ALUOut  output  WIDTH  registered result
- FlagsOut  output  4  {Z,C,N,O}, bit3=Z … bit0=O
- Busy  output  1  high while multiply iterates
- Done  output  1  one-cycle pulse when result/flags updated

Behaviour:
- Reset low (any time, incl. mid-multiply): ALUOut=0, FlagsOut=0, Busy=0, Done=0, FSM=IDLE, multiplier state cleared; takes effect immediately, not at the edge.
- FSM states: IDLE, MUL, FIN.
  - IDLE + Start + single-cycle op: result and flags written at the same edge; Done=1 for the following cycle; stay IDLE.
  - IDLE + Start + FunSel=10000: latch A, B and WF; Busy=1; go to MUL.
  - MUL: one shift-add step per edge; after MUL_CYCLES steps go to FIN.
  - FIN: write ALUOut and flags; Busy=0; Done=1 for one cycle; return to IDLE.
- Timing: Start sampled at edge k gives multiply Done high in the cycle after edge k+17. Busy is high from edge k+1 through edge k+17.
- Start while Busy: ignored, with no effect on the in-flight operation. Start in the Done cycle is accepted (back-to-back).
- FunSel encoding (unsigned, 5-bit):
  - 00000 A; 00001 B; 00010 ~A; 00011 ~B
  - 00100 A+B; 00101 A+B+Cflag; 00110 A-B
  - 00111 A&B; 01000 A|B; 01001 A^B; 01010 ~(A&B)
  - 01011 LSL A; 01100 LSR A; 01101 ASR A
  - 01110 CSL A (rotate left through C); 01111 CSR A (rotate right through C)
  - 10000 MUL (low WIDTH bits of A*B)
  - 10001–11111 reserved: ALUOut and flags unchanged, Done still pulses.
- Flags (written only if the WF sampled at Start is 1; otherwise flags hold):
  - Z = (result==0); N = result[WIDTH-1], for all non-reserved ops.
  - Add ops: C = carry out of bit WIDTH-1. O = signed overflow (both operands share a sign and the result sign differs).
  - Sub: computed as A+~B+1. C = carry out (1 = no borrow). O = (A sign != B sign) && (result sign != A sign).
  - LSL/CSL: C = A[WIDTH-1]. LSR/ASR/CSR: C = A[0]. O unchanged.
  - Logic, move and NOT ops: C and O unchanged.
  - MUL: C = O = (upper WIDTH bits of product != 0).
- All arithmetic is modulo 2^WIDTH; ADC uses the current C flag value at the Start edge.
- Operands A/B may change after the Start edge; the multiply uses its latched copies.

Decomposition:
- Package alu_pkg holds:
  - FunSel localparams (FS_A … FS_MUL)
  - flag bit indices (FLG_Z=3, FLG_C=2, FLG_N=1, FLG_O=0)
  - FSM state encoding (IDLE, MUL, FIN).
- One sub-module, alu_mul_seq: iterative shift-add multiplier with load/step inputs and 2*WIDTH product output. The top level holds the combinational op logic, FSM, and result/flag registers.

Test Plan:
- Reset low mid-multiply (edge k+5 of MUL) -> ALUOut=0, FlagsOut=0, Busy=0 immediately; next Start with FS_A, A=16'h1234 gives ALUOut=16'h1234 after 1 edge.
- ADD A=16'h7FFF, B=16'h0001, WF=1 -> ALUOut=16'h8000, Z=0, C=0, N=1, O=1; Done pulses 1 cycle.
- SUB A=16'h0003, B=16'h0005, WF=1 -> ALUOut=16'hFFFE, C=0, N=1, O=0, Z=0; repeat with WF=0 -> flags unchanged.
- MUL A=16'h0100, B=16'h0100 -> Busy high 17 cycles, ALUOut=16'h0000, Z=1, C=1, O=1. A second Start mid-Busy is ignored; A/B changed mid-run do not affect the result.
- CSL A=16'h8001 with C=1 -> ALUOut=16'h0003, C=1; then CSR A=16'h0001 with C=0 -> ALUOut=16'h0000, C=1, Z=1.
- Reserved FunSel=11111 with WF=1 -> ALUOut and FlagsOut hold previous values, Done still pulses; back-to-back Start in the Done cycle is accepted.
